// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding register per functional unit, rotating-priority grant of up
// to WAYS held results per cycle, packed into registered common-data-bus lanes.
module cdb_arbiter #(
   parameter int WAYS   = 3,
   parameter int NUM_FU = 6,
   parameter int ROB    = 32,
   parameter int PRF    = 64,
   parameter int XLEN   = 32
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  flush,
   input  logic [NUM_FU-1:0]                     fu_valid,
   input  logic [NUM_FU-1:0][$clog2(ROB)-1:0]    fu_ROB_idx,
   input  logic [NUM_FU-1:0][$clog2(PRF)-1:0]    fu_PRN,
   input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
   input  logic [NUM_FU-1:0]                     fu_direction,
   input  logic [NUM_FU-1:0][XLEN-1:0]           fu_target,
   output logic [NUM_FU-1:0]                     fu_ready,
   output logic [WAYS-1:0]                       CDB_valid,
   output logic [WAYS-1:0][$clog2(ROB)-1:0]      CDB_ROB_idx,
   output logic [WAYS-1:0][$clog2(PRF)-1:0]      CDB_PRN,
   output logic [WAYS-1:0][XLEN-1:0]             CDB_value,
   output logic [WAYS-1:0]                       CDB_direction,
   output logic [WAYS-1:0][XLEN-1:0]             CDB_target,
   output logic [$clog2(NUM_FU):0]               num_pending
);

   localparam int ROB_W = $clog2(ROB);
   localparam int PRF_W = $clog2(PRF);
   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int CNT_W = $clog2(NUM_FU) + 1;

   typedef struct packed {
      logic [ROB_W-1:0] rob_idx;
      logic [PRF_W-1:0] prn;
      logic [XLEN-1:0]  value;
      logic             direction;
      logic [XLEN-1:0]  target;
   } result_t;

   result_t           payload   [NUM_FU];
   result_t           lane_data [WAYS];
   logic [NUM_FU-1:0] held;
   logic [NUM_FU-1:0] grant;
   logic [WAYS-1:0]   lane_used;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_next;
   logic              any_grant;
   int                pos  [NUM_FU];
   int                rank [NUM_FU];
   int                best_pos;
   int                last_fu;

   // pos is the distance from rr_ptr in scan order; rank counts held FUs scanned earlier,
   // so rank doubles as the lane number of a granted FU.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      grant     = '0;
      lane_used = '0;
      best_pos  = -1;
      last_fu   = -1;
      for (int k = 0; k < WAYS; k++) lane_data[k] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         pos[i] = i - int'(rr_ptr);
         if (pos[i] < 0) pos[i] = pos[i] + NUM_FU;
      end
      for (int i = 0; i < NUM_FU; i++) begin
         rank[i] = 0;
         for (int m = 0; m < NUM_FU; m++)
            if (held[m] && pos[m] < pos[i]) rank[i] = rank[i] + 1;
         grant[i] = held[i] && (rank[i] < WAYS);
      end
      for (int i = 0; i < NUM_FU; i++) begin
         for (int k = 0; k < WAYS; k++) begin
            if (grant[i] && rank[i] == k) begin
               lane_used[k] = 1'b1;
               lane_data[k] = payload[i];
            end
         end
         if (grant[i] && pos[i] > best_pos) begin
            best_pos = pos[i];
            last_fu  = i;
         end
      end
      any_grant = |grant;
      rr_next   = (last_fu >= NUM_FU - 1 || last_fu < 0) ? '0 : PTR_W'(last_fu + 1);
   end

   assign fu_ready = ~held | grant;

   always_comb begin
      num_pending = '0;
      for (int i = 0; i < NUM_FU; i++) num_pending = num_pending + CNT_W'(held[i]);
   end

   // NOTE: payload registers carry no reset; held alone says whether their contents mean anything.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (fu_valid[i] && fu_ready[i]) begin
            payload[i] <= '{rob_idx:   fu_ROB_idx[i],
                            prn:       fu_PRN[i],
                            value:     fu_value[i],
                            direction: fu_direction[i],
                            target:    fu_target[i]};
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         held          <= '0;
         rr_ptr        <= '0;
         CDB_valid     <= '0;
         CDB_ROB_idx   <= '0;
         CDB_PRN       <= '0;
         CDB_value     <= '0;
         CDB_direction <= '0;
         CDB_target    <= '0;
      end else if (flush) begin
         held          <= '0;
         CDB_valid     <= '0;
         CDB_ROB_idx   <= '0;
         CDB_PRN       <= '0;
         CDB_value     <= '0;
         CDB_direction <= '0;
         CDB_target    <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) held[i] <= 1'b1;
            else if (grant[i])              held[i] <= 1'b0;
         end
         for (int k = 0; k < WAYS; k++) begin
            CDB_valid[k]     <= lane_used[k];
            CDB_ROB_idx[k]   <= lane_data[k].rob_idx;
            CDB_PRN[k]       <= lane_data[k].prn;
            CDB_value[k]     <= lane_data[k].value;
            CDB_direction[k] <= lane_data[k].direction;
            CDB_target[k]    <= lane_data[k].target;
         end
         if (any_grant) rr_ptr <= rr_next;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: table of per-cycle vectors plus directed sequences for
// latency, full-width grants, a single-lane build, index wrap and flush.
module tb_cdb_arbiter;

   localparam int WAYS   = 3;
   localparam int NUM_FU = 6;
   localparam int ROB    = 32;
   localparam int PRF    = 64;
   localparam int XLEN   = 32;
   localparam int RW     = 5;
   localparam int PW     = 6;
   localparam int NONE   = 7;

   logic                           clock, reset, flush;
   logic [NUM_FU-1:0]              fu_valid, fu_valid1;
   logic [NUM_FU-1:0][RW-1:0]      fu_ROB_idx;
   logic [NUM_FU-1:0][PW-1:0]      fu_PRN;
   logic [NUM_FU-1:0][XLEN-1:0]    fu_value;
   logic [NUM_FU-1:0]              fu_direction;
   logic [NUM_FU-1:0][XLEN-1:0]    fu_target;
   logic [NUM_FU-1:0]              fu_ready, fu_ready1;
   logic [WAYS-1:0]                CDB_valid;
   logic [WAYS-1:0][RW-1:0]        CDB_ROB_idx;
   logic [WAYS-1:0][PW-1:0]        CDB_PRN;
   logic [WAYS-1:0][XLEN-1:0]      CDB_value;
   logic [WAYS-1:0]                CDB_direction;
   logic [WAYS-1:0][XLEN-1:0]      CDB_target;
   logic [3:0]                     num_pending, num_pending1;
   logic [0:0]                     CDB_valid1;
   logic [0:0][RW-1:0]             CDB_ROB_idx1;
   logic [0:0][PW-1:0]             CDB_PRN1;
   logic [0:0][XLEN-1:0]           CDB_value1;
   logic [0:0]                     CDB_direction1;
   logic [0:0][XLEN-1:0]           CDB_target1;

   int total = 0;
   int bad   = 0;

   cdb_arbiter #(.WAYS(WAYS), .NUM_FU(NUM_FU), .ROB(ROB), .PRF(PRF), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .fu_valid(fu_valid), .fu_ROB_idx(fu_ROB_idx), .fu_PRN(fu_PRN), .fu_value(fu_value),
      .fu_direction(fu_direction), .fu_target(fu_target), .fu_ready(fu_ready),
      .CDB_valid(CDB_valid), .CDB_ROB_idx(CDB_ROB_idx), .CDB_PRN(CDB_PRN),
      .CDB_value(CDB_value), .CDB_direction(CDB_direction), .CDB_target(CDB_target),
      .num_pending(num_pending)
   );

   cdb_arbiter #(.WAYS(1), .NUM_FU(NUM_FU), .ROB(ROB), .PRF(PRF), .XLEN(XLEN)) dut1 (
      .clock(clock), .reset(reset), .flush(flush),
      .fu_valid(fu_valid1), .fu_ROB_idx(fu_ROB_idx), .fu_PRN(fu_PRN), .fu_value(fu_value),
      .fu_direction(fu_direction), .fu_target(fu_target), .fu_ready(fu_ready1),
      .CDB_valid(CDB_valid1), .CDB_ROB_idx(CDB_ROB_idx1), .CDB_PRN(CDB_PRN1),
      .CDB_value(CDB_value1), .CDB_direction(CDB_direction1), .CDB_target(CDB_target1),
      .num_pending(num_pending1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   typedef struct {
      logic [NUM_FU-1:0]     valid;
      logic [WAYS-1:0]       cdb_valid;
      logic [WAYS-1:0][2:0]  lane_fu;
      logic [NUM_FU-1:0]     ready;
      int                    pending;
   } vec_t;

   function automatic vec_t mk(logic [5:0] v, logic [2:0] cv, int l0, int l1, int l2,
                               logic [5:0] rdy, int pend);
      vec_t r;
      r.valid      = v;
      r.cdb_valid  = cv;
      r.lane_fu[0] = 3'(l0);
      r.lane_fu[1] = 3'(l1);
      r.lane_fu[2] = 3'(l2);
      r.ready      = rdy;
      r.pending    = pend;
      return r;
   endfunction

   // Default payload of each FU is a fixed function of its index.
   function automatic logic [RW-1:0]   d_rob(int fu); return RW'(10 + fu);                 endfunction
   function automatic logic [PW-1:0]   d_prn(int fu); return PW'(40 + fu);                 endfunction
   function automatic logic [XLEN-1:0] d_val(int fu); return 32'hA000_0000 + 32'(fu * 273); endfunction
   function automatic logic            d_dir(int fu); return (fu % 2) == 1;                 endfunction
   function automatic logic [XLEN-1:0] d_tgt(int fu); return 32'h0040_0000 + 32'(fu * 4);   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_default_payload();
      for (int i = 0; i < NUM_FU; i++) begin
         fu_ROB_idx[i]   = d_rob(i);
         fu_PRN[i]       = d_prn(i);
         fu_value[i]     = d_val(i);
         fu_direction[i] = d_dir(i);
         fu_target[i]    = d_tgt(i);
      end
   endtask

   task automatic do_reset();
      fu_valid  = '0;
      fu_valid1 = '0;
      flush     = 1'b0;
      reset     = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic check_lanes(input string tag, input logic [WAYS-1:0][2:0] lf);
      for (int k = 0; k < WAYS; k++) begin
         if (int'(lf[k]) == NONE) begin
            check($sformatf("%s lane%0d valid", tag, k), 64'(CDB_valid[k]), 64'd0);
            check($sformatf("%s lane%0d value", tag, k), 64'(CDB_value[k]), 64'd0);
         end else begin
            check($sformatf("%s lane%0d valid", tag, k), 64'(CDB_valid[k]), 64'd1);
            check($sformatf("%s lane%0d rob", tag, k), 64'(CDB_ROB_idx[k]), 64'(d_rob(int'(lf[k]))));
            check($sformatf("%s lane%0d prn", tag, k), 64'(CDB_PRN[k]), 64'(d_prn(int'(lf[k]))));
            check($sformatf("%s lane%0d value", tag, k), 64'(CDB_value[k]), 64'(d_val(int'(lf[k]))));
            check($sformatf("%s lane%0d dir", tag, k), 64'(CDB_direction[k]), 64'(d_dir(int'(lf[k]))));
            check($sformatf("%s lane%0d target", tag, k), 64'(CDB_target[k]), 64'(d_tgt(int'(lf[k]))));
         end
      end
   endtask

   vec_t vecs [13];

   initial begin
      // Each row: inputs applied for one cycle, then state observed after the edge.
      vecs[0]  = mk(6'b000001, 3'b000, NONE, NONE, NONE, 6'b111111, 1);
      vecs[1]  = mk(6'b000000, 3'b001, 0,    NONE, NONE, 6'b111111, 0);
      vecs[2]  = mk(6'b110110, 3'b000, NONE, NONE, NONE, 6'b011111, 4);
      vecs[3]  = mk(6'b000000, 3'b111, 1,    2,    4,    6'b111111, 1);
      vecs[4]  = mk(6'b001001, 3'b001, 5,    NONE, NONE, 6'b111111, 2);
      vecs[5]  = mk(6'b100000, 3'b011, 0,    3,    NONE, 6'b111111, 1);
      vecs[6]  = mk(6'b111111, 3'b001, 5,    NONE, NONE, 6'b000111, 6);
      vecs[7]  = mk(6'b000000, 3'b111, 0,    1,    2,    6'b111111, 3);
      vecs[8]  = mk(6'b000000, 3'b111, 3,    4,    5,    6'b111111, 0);
      vecs[9]  = mk(6'b000000, 3'b000, NONE, NONE, NONE, 6'b111111, 0);
      vecs[10] = mk(6'b011100, 3'b000, NONE, NONE, NONE, 6'b111111, 3);
      vecs[11] = mk(6'b100011, 3'b111, 2,    3,    4,    6'b111111, 3);
      vecs[12] = mk(6'b000000, 3'b111, 5,    0,    1,    6'b111111, 0);

      set_default_payload();

      // Reset state
      do_reset();
      check("reset cdb_valid", 64'(CDB_valid), 64'd0);
      check("reset num_pending", 64'(num_pending), 64'd0);
      check("reset fu_ready", 64'(fu_ready), 64'h3f);
      check("reset rr_ptr", 64'(dut.rr_ptr), 64'd0);
      check("reset w1 cdb_valid", 64'(CDB_valid1), 64'd0);
      check("reset w1 fu_ready", 64'(fu_ready1), 64'h3f);

      // Vector table
      for (int r = 0; r < 13; r++) begin
         fu_valid = vecs[r].valid;
         step();
         fu_valid = '0;
         check($sformatf("row%0d cdb_valid", r), 64'(CDB_valid), 64'(vecs[r].cdb_valid));
         check($sformatf("row%0d fu_ready", r), 64'(fu_ready), 64'(vecs[r].ready));
         check($sformatf("row%0d pending", r), 64'(num_pending), 64'(vecs[r].pending));
         check_lanes($sformatf("row%0d", r), vecs[r].lane_fu);
      end

      // Single result, two-cycle latency
      do_reset();
      fu_ROB_idx[2] = 5'd5; fu_PRN[2] = 6'd17; fu_value[2] = 32'hDEADBEEF;
      fu_direction[2] = 1'b1; fu_target[2] = 32'h0000_1234;
      fu_valid = 6'b000100;
      step();
      fu_valid = '0;
      check("lat t1 cdb_valid", 64'(CDB_valid), 64'd0);
      check("lat t1 pending", 64'(num_pending), 64'd1);
      step();
      check("lat t2 cdb_valid", 64'(CDB_valid), 64'b001);
      check("lat t2 rob", 64'(CDB_ROB_idx[0]), 64'd5);
      check("lat t2 prn", 64'(CDB_PRN[0]), 64'd17);
      check("lat t2 value", 64'(CDB_value[0]), 64'hDEADBEEF);
      check("lat t2 dir", 64'(CDB_direction[0]), 64'd1);
      check("lat t2 target", 64'(CDB_target[0]), 64'h1234);
      step();
      check("lat t3 cdb_valid", 64'(CDB_valid), 64'd0);
      check("lat t3 value", 64'(CDB_value[0]), 64'd0);
      set_default_payload();

      // All six FUs at once
      do_reset();
      fu_valid = 6'b111111;
      step();
      fu_valid = '0;
      check("all6 pending", 64'(num_pending), 64'd6);
      check("all6 fu_ready", 64'(fu_ready), 64'b000111);
      step();
      check_lanes("all6 c1", {3'd2, 3'd1, 3'd0});
      check("all6 c1 rr_ptr", 64'(dut.rr_ptr), 64'd3);
      step();
      check_lanes("all6 c2", {3'd5, 3'd4, 3'd3});
      check("all6 rr_ptr end", 64'(dut.rr_ptr), 64'd0);

      // Single-lane build alternates FU0 and FU1
      begin
         int grants [2];
         int fu;
         grants[0] = 0;
         grants[1] = 0;
         do_reset();
         fu_valid1 = 6'b000011;
         step();
         check("w1 first cdb_valid", 64'(CDB_valid1), 64'd0);
         for (int c = 2; c < 10; c++) begin
            step();
            fu = (c % 2 == 0) ? 0 : 1;
            check($sformatf("w1 c%0d valid", c), 64'(CDB_valid1), 64'd1);
            check($sformatf("w1 c%0d rob", c), 64'(CDB_ROB_idx1[0]), 64'(d_rob(fu)));
            check($sformatf("w1 c%0d ready", c), 64'(fu_ready1),
                  64'(6'b111100 | ((fu == 0) ? 6'b000010 : 6'b000001)));
            if (CDB_valid1[0] && CDB_ROB_idx1[0] == d_rob(0)) grants[0]++;
            if (CDB_valid1[0] && CDB_ROB_idx1[0] == d_rob(1)) grants[1]++;
         end
         check("w1 fu0 grants", 64'(grants[0]), 64'd4);
         check("w1 fu1 grants", 64'(grants[1]), 64'd4);
         fu_valid1 = '0;
      end

      // Back-to-back from one FU with wrapping ROB index
      do_reset();
      for (int i = 0; i < 34; i++) begin
         fu_valid      = 6'b000010;
         fu_ROB_idx[1] = RW'(i % 32);
         fu_value[1]   = 32'(i);
         step();
         check($sformatf("stream i%0d ready1", i), 64'(fu_ready[1]), 64'd1);
         if (i >= 1) begin
            check($sformatf("stream i%0d valid", i), 64'(CDB_valid), 64'b001);
            check($sformatf("stream i%0d rob", i), 64'(CDB_ROB_idx[0]), 64'((i - 1) % 32));
            check($sformatf("stream i%0d value", i), 64'(CDB_value[0]), 64'(i - 1));
         end
      end
      fu_valid = '0;
      step();
      check("stream last rob", 64'(CDB_ROB_idx[0]), 64'd1);
      check("stream last value", 64'(CDB_value[0]), 64'd33);
      set_default_payload();

      // Flush with four held and one incoming
      do_reset();
      fu_valid = 6'b000001;
      step();
      fu_valid = '0;
      step();
      check("flush pre rr_ptr", 64'(dut.rr_ptr), 64'd1);
      fu_valid = 6'b011110;
      step();
      check("flush pre pending", 64'(num_pending), 64'd4);
      fu_valid = 6'b100000;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      fu_valid = '0;
      check("flush cdb_valid", 64'(CDB_valid), 64'd0);
      check("flush cdb_value", 64'(CDB_value), 64'd0);
      check("flush cdb_rob", 64'(CDB_ROB_idx), 64'd0);
      check("flush pending", 64'(num_pending), 64'd0);
      check("flush fu_ready", 64'(fu_ready), 64'h3f);
      check("flush rr_ptr", 64'(dut.rr_ptr), 64'd1);
      step();
      check("flush after cdb_valid", 64'(CDB_valid), 64'd0);
      check("flush after pending", 64'(num_pending), 64'd0);

      // Reset wins over a simultaneous flush
      reset = 1'b1;
      flush = 1'b1;
      step();
      reset = 1'b0;
      flush = 1'b0;
      check("reset+flush rr_ptr", 64'(dut.rr_ptr), 64'd0);
      check("reset+flush pending", 64'(num_pending), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
